// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl -- two-requester round-robin front end for a shared alu_8bit.
//
// A command is granted in IDLE, its operands are held on the ALU port
// during EXEC, and the ALU result and flags are captured into a response
// register. The response is then held in WAIT_RSP until the consumer
// accepts it. Only one command is in flight at any time.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   req{0,1}_valid / req{0,1}_ready    command handshake per requester
//   req{0,1}_a, _b, _sel               command payload (operands, select)
//   alu_a, alu_b, alu_select           operands driven to the shared ALU
//   alu_result, alu_carry/overflow/zero/negative   ALU outputs
//   rsp_valid / rsp_ready              response handshake
//   rsp_id, rsp_result, rsp_flags      response payload, flags = {C,V,Z,N}
//   rsp_err                            select code was out of range
//   busy                               controller is not in IDLE
//   ops_done                           wrapping count of consumed responses
module alu_arb_ctrl #(
    parameter int NUM_OPS = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_select,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_negative,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    // One extra bit so a NUM_OPS of 16 still compares correctly.
    localparam logic [4:0] NUM_OPS_W = 5'(NUM_OPS);

    state_t      state_reg, state_next;
    logic        rr_ptr_reg;
    logic [7:0]  a_reg, b_reg;
    logic [3:0]  sel_reg;
    logic        id_reg;
    logic        rsp_valid_reg;
    logic        rsp_id_reg;
    logic [7:0]  rsp_result_reg;
    logic [3:0]  rsp_flags_reg;
    logic        rsp_err_reg;
    logic [15:0] ops_done_reg;

    logic        grant_valid;
    logic        grant_id;
    logic        sel_bad;
    logic        rsp_fire;

    // Ready is combinational from valid, so it is gated by rst_n to stay
    // low while the block is held in reset.
    assign grant_valid = rst_n && (req0_valid || req1_valid);
    // With both valid the rr_ptr side wins; otherwise whoever is valid wins.
    assign grant_id    = (req0_valid && req1_valid) ? rr_ptr_reg : req1_valid;
    assign sel_bad     = ({1'b0, sel_reg} >= NUM_OPS_W);
    // rsp_valid is always high in WAIT_RSP, so rsp_ready alone completes it.
    assign rsp_fire    = (state_reg == WAIT_RSP) && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    req0_ready = (grant_id == 1'b0);
                    req1_ready = (grant_id == 1'b1);
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                // No grant here: the earliest new grant is the next IDLE cycle.
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, response capture and bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg     <= 1'b0;
            a_reg          <= 8'd0;
            b_reg          <= 8'd0;
            sel_reg        <= 4'd0;
            id_reg         <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= 8'd0;
            rsp_flags_reg  <= 4'd0;
            rsp_err_reg    <= 1'b0;
            ops_done_reg   <= 16'd0;
        end else begin
            if ((state_reg == IDLE) && grant_valid) begin
                a_reg   <= grant_id ? req1_a   : req0_a;
                b_reg   <= grant_id ? req1_b   : req0_b;
                sel_reg <= grant_id ? req1_sel : req0_sel;
                id_reg  <= grant_id;
            end

            if (state_reg == EXEC) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= id_reg;
                if (sel_bad) begin
                    rsp_result_reg <= 8'd0;
                    rsp_flags_reg  <= 4'd0;
                    rsp_err_reg    <= 1'b1;
                end else begin
                    rsp_result_reg <= alu_result;
                    rsp_flags_reg  <= {alu_carry, alu_overflow, alu_zero, alu_negative};
                    rsp_err_reg    <= 1'b0;
                end
            end

            if (rsp_fire) begin
                rsp_valid_reg <= 1'b0;
                // Hand priority to the requester that was not just served.
                rr_ptr_reg    <= ~rsp_id_reg;
                ops_done_reg  <= ops_done_reg + 16'd1;
            end
        end
    end

    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign alu_select = sel_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_flags  = rsp_flags_reg;
    assign rsp_err    = rsp_err_reg;
    assign busy       = (state_reg != IDLE);
    assign ops_done   = ops_done_reg;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Testbench for alu_arb_ctrl. A small behavioural alu_8bit model is attached
// to the ALU port; expected responses are hand-computed constants.
// Codes 0..10: add, sub, and, or, xor, not a, shl a, shr a, inc a, dec a, pass b.
// Flags {C,V,Z,N}; codes >= 11 return deliberate garbage that the DUT must drop.
module tb_alu_arb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_select;
    logic [7:0]  alu_result;
    logic        alu_carry, alu_overflow, alu_zero, alu_negative;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] ops_done;

    int          checks;
    int          failures;
    logic [15:0] exp_ops;

    alu_arb_ctrl #(.NUM_OPS(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] s);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (s)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd7:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd8:  begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
            4'd9:  begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
            4'd10: r = b;
            default: return {4'hF, a ^ b ^ 8'h5A};
        endcase
        return {c, v, (r == 8'd0), r[7], r};
    endfunction

    always_comb begin
        logic [11:0] m;
        m = alu_model(alu_a, alu_b, alu_select);
        {alu_carry, alu_overflow, alu_zero, alu_negative} = m[11:8];
        alu_result = m[7:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_r;
        logic [3:0] exp_f;
        logic       exp_e;
    } vec_t;

    vec_t vecs[17];

    // One isolated command from requester id, consumer always ready.
    task automatic run_txn(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sel, input logic [7:0] er,
                           input logic [3:0] ef, input logic ee);
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = (id == 1'b0);
        req1_valid = (id == 1'b1);
        if (id == 1'b0) begin req0_a = a; req0_b = b; req0_sel = sel; end
        else            begin req1_a = a; req1_b = b; req1_sel = sel; end
        #1;
        check("grant_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
        check("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
        // EXEC: payload on the request side is scrambled to prove it was latched.
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req0_sel = ~sel;
        req1_a = ~a; req1_b = ~b; req1_sel = ~sel;
        #1;
        check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_sel", 32'(alu_select), 32'(sel));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_result", 32'(rsp_result), 32'(er));
        check("rsp_flags", 32'(rsp_flags), 32'(ef));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        exp_ops = exp_ops + 16'd1;
        @(negedge clk);
        #1;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("ops_done", 32'(ops_done), 32'(exp_ops));
        $display("txn id=%0d a=%02h b=%02h sel=%0d -> result=%02h flags=%01h err=%0d ops_done=%0d",
                 id, a, b, sel, rsp_result, rsp_flags, rsp_err, ops_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic winner;
        int   waited;
        checks = 0; failures = 0; exp_ops = 16'd0;

        //         id    a      b      sel    result flags err
        vecs[0]  = '{1'b0, 8'h05, 8'h04, 4'd0,  8'h09, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 8'h01, 8'h00, 4'd0,  8'h01, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 8'h02, 8'h01, 4'd1,  8'h01, 4'h0, 1'b0};
        vecs[3]  = '{1'b0, 8'h03, 8'h02, 4'd2,  8'h02, 4'h0, 1'b0};
        vecs[4]  = '{1'b1, 8'h04, 8'h03, 4'd3,  8'h07, 4'h0, 1'b0};
        vecs[5]  = '{1'b0, 8'h05, 8'h04, 4'd4,  8'h01, 4'h0, 1'b0};
        vecs[6]  = '{1'b1, 8'h06, 8'h05, 4'd5,  8'hF9, 4'h1, 1'b0};
        vecs[7]  = '{1'b0, 8'h07, 8'h06, 4'd6,  8'h0E, 4'h0, 1'b0};
        vecs[8]  = '{1'b1, 8'h08, 8'h07, 4'd7,  8'h04, 4'h0, 1'b0};
        vecs[9]  = '{1'b0, 8'h09, 8'h08, 4'd8,  8'h0A, 4'h0, 1'b0};
        vecs[10] = '{1'b1, 8'h0A, 8'h09, 4'd9,  8'h09, 4'h0, 1'b0};
        vecs[11] = '{1'b0, 8'h0B, 8'h0A, 4'd10, 8'h0A, 4'h0, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 8'h01, 4'd0,  8'h00, 4'hA, 1'b0};
        vecs[13] = '{1'b0, 8'h7F, 8'h01, 4'd0,  8'h80, 4'h5, 1'b0};
        vecs[14] = '{1'b1, 8'h00, 8'h01, 4'd1,  8'hFF, 4'h9, 1'b0};
        vecs[15] = '{1'b1, 8'h33, 8'h44, 4'hC,  8'h00, 4'h0, 1'b1};
        vecs[16] = '{1'b0, 8'h21, 8'h12, 4'hB,  8'h00, 4'h0, 1'b1};

        // Reset with both requesters already valid: nothing may be granted.
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h0A; req0_b = 8'h03; req0_sel = 4'd1;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h0A; req1_sel = 4'd1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_select}), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);

        // Contention: both valid from reset, grants must go 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            #1;
            while (!(req0_ready || req1_ready) && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("cont_grant_seen", 32'(req0_ready || req1_ready), 32'd1);
            check("cont_one_hot", 32'(req0_ready && req1_ready), 32'd0);
            check("cont_order", 32'(req1_ready), 32'(k % 2));
            winner = req1_ready;
            @(negedge clk);
            @(negedge clk);
            #1;
            check("cont_rsp_valid", 32'(rsp_valid), 32'd1);
            check("cont_rsp_id", 32'(rsp_id), 32'(winner));
            check("cont_rsp_result", 32'(rsp_result), winner ? 32'h0F9 : 32'h007);
            check("cont_rsp_flags", 32'(rsp_flags), winner ? 32'h9 : 32'h0);
            exp_ops = exp_ops + 16'd1;
            $display("txn contention k=%0d id=%0d result=%02h", k, rsp_id, rsp_result);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("cont_ops_done", 32'(ops_done), 32'(exp_ops));

        // Directed vectors: single op, sweep 0..10, arithmetic edges, bad ops.
        for (int i = 0; i < 17; i++) begin
            run_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel,
                    vecs[i].exp_r, vecs[i].exp_f, vecs[i].exp_e);
        end

        // Backpressure: hold the response for 5 cycles with req1 waiting.
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h11; req0_sel = 4'd0;
        #1;
        check("bp_grant0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h01; req1_sel = 4'd2;
        #1;
        check("bp_exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'({1'b0, 8'h31, 4'h0, 1'b0}));
            check("bp_hold_busy", 32'(busy), 32'd1);
            check("bp_hold_ready", 32'(req1_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_consume_no_grant", 32'(req1_ready), 32'd0);
        check("bp_consume_valid", 32'(rsp_valid), 32'd1);
        exp_ops = exp_ops + 16'd1;
        $display("txn backpressure id=0 result=%02h", rsp_result);
        @(negedge clk);
        #1;
        check("bp_next_grant", 32'(req1_ready), 32'd1);
        check("bp_ops_done", 32'(ops_done), 32'(exp_ops));
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("bp_rsp1", 32'({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}),
              32'({1'b1, 1'b1, 8'h00, 4'h2, 1'b0}));
        exp_ops = exp_ops + 16'd1;
        $display("txn backpressure id=1 result=%02h flags=%01h", rsp_result, rsp_flags);
        @(negedge clk);
        #1;
        check("bp_ops_done2", 32'(ops_done), 32'(exp_ops));

        // Reset while the command is in EXEC: it must vanish without a response.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_sel = 4'd3;
        #1;
        check("rx_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        exp_ops = 16'd0;
        #1;
        check("rx_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rx_busy", 32'(busy), 32'd0);
        check("rx_ops_done", 32'(ops_done), 32'd0);
        check("rx_alu", 32'({alu_a, alu_b, alu_select}), 32'd0);
        check("rx_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rx_no_rsp", 32'({rsp_valid, busy}), 32'd0);
        end
        $display("txn reset_in_exec dropped ops_done=%0d", ops_done);
        run_txn(1'b0, 8'h12, 8'h34, 4'd3, 8'h36, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter NUM_OPS, default 11, number of valid select codes (0..NUM_OPS-1) on the shared alu_8bit.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a command.
REQ-005 req0_ready / req1_ready  output  1  command from requester N accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8  operands.
REQ-007 req0_sel / req1_sel  input  4  ALU select code.
REQ-008 alu_a, alu_b  output  8  operands driven to alu_8bit.
REQ-009 alu_select  output  4  select driven to alu_8bit.
REQ-010 alu_result  input  8  alu_8bit result.
REQ-011 alu_carry, alu_overflow, alu_zero, alu_negative  input  1  alu_8bit flags.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index of the response.
REQ-015 rsp_result  output  8  captured result.
REQ-016 rsp_flags  output  4  {C,V,Z,N} captured flags.
REQ-017 rsp_err  output  1  select code was >= NUM_OPS.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 ops_done  output  16  count of completed responses.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and WAIT_RSP.
REQ-021 IDLE: if any reqN_valid is high, grant exactly one requester, assert its reqN_ready combinationally for that cycle only, latch a/b/sel/id, and go to EXEC next edge.
REQ-022 Arbitration SHALL be round-robin: rr_ptr resets to 0; the requester equal to rr_ptr wins when both are valid; the other wins when alone.
REQ-023 reqN_ready SHALL be 0 in EXEC and WAIT_RSP, and 0 for the non-granted requester.
REQ-024 alu_a, alu_b and alu_select SHALL be driven from the latched registers and stay stable from the cycle after grant until the next grant.
REQ-025 EXEC (one cycle): at its closing edge, capture alu_result and flags into rsp_result/rsp_flags, set rsp_err=0, rsp_valid=1, and go to WAIT_RSP.
REQ-026 If latched sel >= NUM_OPS, EXEC SHALL instead set rsp_result=0, rsp_flags=0, rsp_err=1 and rsp_valid=1; ALU outputs are ignored.
REQ-027 Latency: accept at edge T, rsp_valid high after edge T+2; max throughput one command per 3 cycles.
REQ-028 WAIT_RSP: hold all rsp_* stable while rsp_ready=0; on rsp_valid&&rsp_ready, clear rsp_valid, set rr_ptr = ~rsp_id, increment ops_done, and go to IDLE.
REQ-029 ops_done SHALL wrap from 16'hFFFF to 0; error responses count.
REQ-030 A new command SHALL NOT be granted in the cycle a response is consumed; earliest grant is the following IDLE cycle.
REQ-031 A requester holding valid while not ready keeps its payload; the block samples only at grant.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, all latched operands/select=0 (so alu_a/alu_b/alu_select=0), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, ops_done=0, busy=0, req ready=0.
REQ-033 Reset mid-transaction SHALL drop it with no response; operation resumes the first edge after rst_n rises.

Verification
REQ-034 Single op: alu_8bit attached, rsp_ready=1, req0 a=8'h05 b=8'h04 sel=0 -> req0_ready 1 cycle, rsp_valid at T+2, rsp_id=0, result/flags equal alu_8bit(5,4,0), ops_done=1.
REQ-035 Contention: both valid from reset, sel=1 -> grant order 0,1,0,1; rsp_id alternates; no requester starves.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, busy=1, no new ready; rsp_ready=1 -> consumed, grant next IDLE cycle.
REQ-037 Bad op: req1 sel=4'hC -> rsp_err=1, rsp_result=0, rsp_flags=0, rsp_id=1, ops_done increments.
REQ-038 Reset in EXEC: rst_n low one cycle -> rsp_valid=0, outputs at reset values, ops_done=0, no response for the dropped command.
REQ-039 Sweep sel 0..10 with A=sel+1, B=sel -> each response matches alu_8bit for that input; ops_done=11.
